id_ex_hazard_ctrl: RTL and testbench
====================================

// Module: id_ex_hazard_ctrl
// PURPOSE
//  Sequencer for the ID->EX boundary of the 5-stage pipeline. Detects RAW/load-use hazards and inserts bubbles.
//  Applies branch flush and external halt. Registers the decoded immediate-extension result and its op
//  (sign/zero/shamt) into the ID/EX register, so EX sees a clean, bubble-aware immediate.
// PARAMETERS
//  CNT_W   16   width of saturating bubble-cycle counter stall_cnt
// PORTS
//  clk              in   1   pipeline clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  id_valid         in   1   ID stage holds a real instruction
//  id_rs / id_rt    in   5   ID source register numbers
//  id_uses_rs/_rt   in   1   ID instruction actually reads rs / rt
//  id_imm           in   16  instr[15:0]
//  id_shamt         in   5   instr[10:6]
//  id_ext_op        in   2   00 sign-ext imm, 01 zero-ext imm, 10 zero-ext shamt, 11 reserved
//  ex_mem_read      in   1   EX instruction is a load
//  ex_reg_write     in   1   EX instruction writes a register
//  ex_wr_reg        in   5   EX destination
//  mem_reg_write    in   1   MEM instruction writes a register
//  mem_wr_reg       in   5   MEM destination
//  ex_branch_taken  in   1   taken branch/jump resolved in EX
//  halt_req         in   1   level request to freeze the front end (syscall/debug)
//  pc_stall         out  1   hold PC (combinational)
//  ifid_stall       out  1   hold IF/ID (combinational)
//  ifid_flush       out  1   clear IF/ID (combinational)
//  idex_valid       out  1   ID/EX slot holds real instruction (registered)
//  idex_ext_op      out  2   registered ext op
//  idex_imm32       out  32  registered extended immediate
//  halted           out  1   FSM in HALT (registered)
//  stall_cnt        out  CNT_W  bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registered outputs 0, FSM=RUN; comb outputs 0 while in reset.
//  - Extension: 00 {{16{imm[15]}},imm}; 01 {16'b0,imm}; 10 {27'b0,shamt}; 11 32'h0. Never latch.
//  - Hazard match m(r,w,d) = id_valid & uses & w & (d==r) & (r!=0); $zero never hazards.
//  - HZ (forwarding build) = load-use only: ex_mem_read & m(rs|rt, ex_reg_write, ex_wr_reg).
//  - FSM RUN / STALL / HALT; priority per cycle: reset > halt > branch > hazard > advance.
//  - HALT: entered from any state when halt_req=1 and !ex_branch_taken. pc_stall=ifid_stall=1, idex_valid<=0,
//    halted<=1. Leave to RUN on the first edge with halt_req=0; that edge loads ID/EX normally.
//  - Branch: ex_branch_taken=1 -> ifid_flush=1, pc_stall=ifid_stall=0, idex_valid<=0, FSM->RUN.
//    A simultaneous hazard is discarded; the flushed instruction is dead. Branch beats halt in the same cycle;
//    halt is taken on the next cycle if still requested.
//  - Hazard (RUN/STALL, no branch, HZ=1): pc_stall=ifid_stall=1, idex_valid<=0 (bubble), FSM->STALL,
//    stall_cnt+=1 saturating at all-ones.
//  - Advance (no hazard): idex_valid<=id_valid; idex_ext_op<=id_ext_op; idex_imm32<=ext result; FSM->RUN.
//  - idex_imm32/idex_ext_op hold their value during bubbles; only idex_valid is cleared.
//  - HZ is evaluated every cycle from live inputs; the stall length is whatever the pipeline presents (1 with forwarding).
//  - Zero-cycle decision latency: comb outputs respond to current-cycle inputs.
// CONFIGURATION
//  - HAZ_FORWARD_EN defined: HZ = load-use only as above, so each load-use costs exactly 1 bubble.
//  - Not defined (no forwarding network): HZ = m(rs|rt, ex_reg_write, ex_wr_reg) | m(rs|rt, mem_reg_write, mem_wr_reg).
//    A dependent instruction stalls up to 2 cycles; the FSM remains in STALL across consecutive bubbles.
// TESTING
//  1 ext: id_imm=16'h8001, op 00/01/10(shamt=5'd17)/11 -> idex_imm32 8000_8001 wait FFFF_8001, 0000_8001, 0000_0011, 0.
//  2 load-use (FORWARD_EN): ex lw $8, id rs=$8 -> 1 cycle pc_stall=1, idex_valid=0, stall_cnt 0->1, then advance.
//  3 no FORWARD_EN: ex add $9, id rt=$9 -> 2 bubble cycles (EX then MEM match), stall_cnt=2; rs=$0 -> no stall.
//  4 branch+hazard same cycle -> ifid_flush=1, pc_stall=0, idex_valid=0, stall_cnt unchanged.
//  5 halt_req 3 cycles -> halted=1 for 3 cycles, front end held, normal advance on first cycle after release.
//  6 rst_n low mid-STALL (async, between edges) -> all outputs 0 immediately; restart in RUN; counter saturates at 16'hFFFF under forced stall.

Source files
------------

// File: rtl/id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_ctrl
//
// Sequencer for the ID->EX boundary of a 5-stage pipeline.
//   * Detects RAW / load-use hazards on the instruction sitting in ID and
//     inserts bubbles into ID/EX while holding PC and IF/ID.
//   * Applies the taken-branch flush resolved in EX and the external halt
//     request used by syscall/debug.
//   * Registers the extended immediate and its extension op into ID/EX so EX
//     always sees a clean immediate; during bubbles only the valid bit drops.
//
// Build option:
//   HAZ_FORWARD_EN  defined   -> a forwarding network exists; only a load in
//                                EX feeding ID is a hazard (1 bubble per
//                                load-use).
//                   undefined -> no forwarding; any pending write in EX or MEM
//                                to a register ID reads is a hazard (up to
//                                2 bubbles).
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   id_valid                      ID holds a real instruction
//   id_rs, id_rt                  ID source register numbers
//   id_uses_rs, id_uses_rt        ID instruction really reads rs / rt
//   id_imm, id_shamt, id_ext_op   immediate fields and extension select
//                                 (00 sign imm, 01 zero imm, 10 zero shamt,
//                                  11 reserved -> 0)
//   ex_mem_read, ex_reg_write,
//   ex_wr_reg                     EX instruction: load flag, write flag, dest
//   mem_reg_write, mem_wr_reg     MEM instruction: write flag, dest
//   ex_branch_taken               taken branch/jump resolved in EX
//   halt_req                      level request to freeze the front end
//   pc_stall, ifid_stall          hold PC / IF-ID (combinational)
//   ifid_flush                    clear IF-ID (combinational)
//   idex_valid, idex_ext_op,
//   idex_imm32                    registered ID/EX slot contents
//   halted                        registered, FSM is in HALT
//   stall_cnt                     saturating count of hazard bubbles
//   dbg_state                     current FSM state (00 RUN, 01 STALL, 10 HALT)
//
// Handshake semantics: this block has no valid/ready pairs; the pipeline
// contract is that a stall output asserted in a cycle means the holding stage
// must not capture new data at the closing edge, and a flush output means the
// IF/ID register captures a bubble at that edge. All decisions are made from
// the inputs of the current cycle (zero-cycle decision latency).
// -----------------------------------------------------------------------------
module id_ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [1:0]       id_ext_op,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_wr_reg,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_wr_reg,
    input  logic             ex_branch_taken,
    input  logic             halt_req,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_valid,
    output logic [1:0]       idex_ext_op,
    output logic [31:0]      idex_imm32,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_idex_valid;
    logic [1:0]       r_idex_ext_op;
    logic [31:0]      r_idex_imm32;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Combinational decision signals
    // ------------------------------------------------------------------
    logic        w_rs_ex;
    logic        w_rt_ex;
    logic        w_rs_mem;
    logic        w_rt_mem;
    logic        w_hz;
    logic        w_take_halt;
    logic        w_take_branch;
    logic        w_take_bubble;
    logic [31:0] w_ext;

    // A source register collides with a pending write only if the ID
    // instruction is real, actually reads that source, the producer really
    // writes, the numbers agree, and the register is not $zero.
    function automatic logic f_match(
        input logic       valid,
        input logic [4:0] src,
        input logic       uses,
        input logic       wr_en,
        input logic [4:0] dst
    );
        return valid & uses & wr_en & (dst == src) & (src != 5'd0);
    endfunction

    assign w_rs_ex  = f_match(id_valid, id_rs, id_uses_rs, ex_reg_write,  ex_wr_reg);
    assign w_rt_ex  = f_match(id_valid, id_rt, id_uses_rt, ex_reg_write,  ex_wr_reg);
    assign w_rs_mem = f_match(id_valid, id_rs, id_uses_rs, mem_reg_write, mem_wr_reg);
    assign w_rt_mem = f_match(id_valid, id_rt, id_uses_rt, mem_reg_write, mem_wr_reg);

`ifdef HAZ_FORWARD_EN
    // Forwarding covers every ALU result; only a load in EX cannot be
    // forwarded in time, so that is the sole hazard. MEM-stage producers are
    // always forwardable and are deliberately ignored here.
    logic w_unused_mem;
    assign w_unused_mem = ^{w_rs_mem, w_rt_mem};
    assign w_hz = ex_mem_read & (w_rs_ex | w_rt_ex);
`else
    // Without forwarding, ID must wait until the producer has left both EX
    // and MEM; the load flag carries no extra meaning in that case.
    logic w_unused_load;
    assign w_unused_load = ex_mem_read;
    assign w_hz = w_rs_ex | w_rt_ex | w_rs_mem | w_rt_mem;
`endif

    // Immediate extension: fully specified for every op so no latch forms.
    always_comb begin
        w_ext = 32'h0000_0000;
        case (id_ext_op)
            2'b00:   w_ext = {{16{id_imm[15]}}, id_imm};
            2'b01:   w_ext = {16'h0000, id_imm};
            2'b10:   w_ext = {27'h0, id_shamt};
            default: w_ext = 32'h0000_0000;
        endcase
    end

    // Per-cycle priority: halt > branch > hazard > advance. A branch in the
    // same cycle as a halt request wins; the halt is honoured on a later
    // cycle if the request is still held.
    assign w_take_halt   = halt_req & ~ex_branch_taken;
    assign w_take_branch = ex_branch_taken;
    assign w_take_bubble = ~halt_req & ~ex_branch_taken & w_hz;

    // Gated by rst_n so the front end sees no stall or flush while in reset.
    assign pc_stall   = rst_n & (w_take_halt | w_take_bubble);
    assign ifid_stall = rst_n & (w_take_halt | w_take_bubble);
    assign ifid_flush = rst_n & w_take_branch;

    // ------------------------------------------------------------------
    // FSM and ID/EX register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_idex_valid  <= 1'b0;
            r_idex_ext_op <= 2'b00;
            r_idex_imm32  <= 32'h0000_0000;
            r_halted      <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (w_take_halt) begin
            // Front end frozen; ID/EX receives a bubble, immediate held.
            r_state      <= ST_HALT;
            r_halted     <= 1'b1;
            r_idex_valid <= 1'b0;
        end else if (w_take_branch) begin
            // The instruction in ID is on the wrong path: kill it. Any hazard
            // it raised is meaningless and is not counted.
            r_state      <= ST_RUN;
            r_halted     <= 1'b0;
            r_idex_valid <= 1'b0;
        end else if (w_take_bubble) begin
            // Stay in STALL for as long as the live inputs keep the hazard up.
            r_state      <= ST_STALL;
            r_halted     <= 1'b0;
            r_idex_valid <= 1'b0;
            if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else begin
            // Advance: also the exit path from HALT and STALL.
            r_state       <= ST_RUN;
            r_halted      <= 1'b0;
            r_idex_valid  <= id_valid;
            r_idex_ext_op <= id_ext_op;
            r_idex_imm32  <= w_ext;
        end
    end

    assign idex_valid  = r_idex_valid;
    assign idex_ext_op = r_idex_ext_op;
    assign idex_imm32  = r_idex_imm32;
    assign halted      = r_halted;
    assign stall_cnt   = r_stall_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_ctrl
//
// Directed bench for id_ex_hazard_ctrl. Each cycle the bench drives inputs,
// checks the combinational stall/flush outputs against its own decision model,
// pushes the expected registered ID/EX contents into exp_q, and pops/compares
// them after the clock edge. Literal spot checks back up the model on the
// values called out for the block (extension results, bubble counts,
// saturation at all-ones).
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int VEC_W = 2 + 1 + 2 + 32 + 1 + CNT_W;

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_STALL = 2'b01;
    localparam logic [1:0] S_HALT  = 2'b10;

`ifdef HAZ_FORWARD_EN
    localparam int LU_BUBBLES  = 1;
    localparam int RAW_BUBBLES = 0;
`else
    localparam int LU_BUBBLES  = 2;
    localparam int RAW_BUBBLES = 2;
`endif

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [15:0]      id_imm;
    logic [4:0]       id_shamt;
    logic [1:0]       id_ext_op;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_wr_reg;
    logic             mem_reg_write;
    logic [4:0]       mem_wr_reg;
    logic             ex_branch_taken;
    logic             halt_req;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_valid;
    logic [1:0]       idex_ext_op;
    logic [31:0]      idex_imm32;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       dbg_state;

    id_ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_imm          (id_imm),
        .id_shamt        (id_shamt),
        .id_ext_op       (id_ext_op),
        .ex_mem_read     (ex_mem_read),
        .ex_reg_write    (ex_reg_write),
        .ex_wr_reg       (ex_wr_reg),
        .mem_reg_write   (mem_reg_write),
        .mem_wr_reg      (mem_wr_reg),
        .ex_branch_taken (ex_branch_taken),
        .halt_req        (halt_req),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_valid      (idex_valid),
        .idex_ext_op     (idex_ext_op),
        .idex_imm32      (idex_imm32),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .dbg_state       (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Scoreboard and reference model state
    // ------------------------------------------------------------------
    int               checks;
    int               failures;
    logic [VEC_W-1:0] exp_q[$];

    logic [1:0]       m_state;
    logic             m_valid;
    logic [1:0]       m_op;
    logic [31:0]      m_imm;
    logic             m_halted;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W-1:0] cnt0;

    function automatic logic [31:0] tb_ext(input logic [1:0] op, input logic [15:0] imm,
                                           input logic [4:0] sh);
        if (op == 2'b00) return {{16{imm[15]}}, imm};
        if (op == 2'b01) return {16'h0000, imm};
        if (op == 2'b10) return {27'h0, sh};
        return 32'h0;
    endfunction

    function automatic logic tb_hit(input logic [4:0] r, input logic uses,
                                    input logic wen, input logic [4:0] d);
        return id_valid && uses && wen && (r == d) && (r != 5'd0);
    endfunction

    function automatic logic tb_hz();
        logic e;
        logic m;
        e = tb_hit(id_rs, id_uses_rs, ex_reg_write, ex_wr_reg) ||
            tb_hit(id_rt, id_uses_rt, ex_reg_write, ex_wr_reg);
        m = tb_hit(id_rs, id_uses_rs, mem_reg_write, mem_wr_reg) ||
            tb_hit(id_rt, id_uses_rt, mem_reg_write, mem_wr_reg);
`ifdef HAZ_FORWARD_EN
        return ex_mem_read && e;
`else
        return e || m;
`endif
    endfunction

    function automatic logic [VEC_W-1:0] obs_regs();
        return {dbg_state, idex_valid, idex_ext_op, idex_imm32, halted, stall_cnt};
    endfunction

    function automatic logic [VEC_W-1:0] model_regs();
        return {m_state, m_valid, m_op, m_imm, m_halted, m_cnt};
    endfunction

    task automatic model_reset();
        m_state  = S_RUN;
        m_valid  = 1'b0;
        m_op     = 2'b00;
        m_imm    = 32'h0;
        m_halted = 1'b0;
        m_cnt    = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        id_valid        = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_imm          = 16'h0;
        id_shamt        = 5'd0;
        id_ext_op       = 2'b00;
        ex_mem_read     = 1'b0;
        ex_reg_write    = 1'b0;
        ex_wr_reg       = 5'd0;
        mem_reg_write   = 1'b0;
        mem_wr_reg      = 5'd0;
        ex_branch_taken = 1'b0;
        halt_req        = 1'b0;
    endtask

    task automatic set_load_use_rs8();
        id_valid     = 1'b1;
        id_rs        = 5'd8;
        id_uses_rs   = 1'b1;
        ex_mem_read  = 1'b1;
        ex_reg_write = 1'b1;
        ex_wr_reg    = 5'd8;
    endtask

    // One clock cycle with the inputs currently driven: check the comb
    // outputs, predict the ID/EX register, clock, then compare.
    task automatic step(input string tag);
        logic       b;
        logic       h;
        logic       hz;
        logic       st;
        #1;
        b  = ex_branch_taken;
        h  = halt_req && !b;
        hz = tb_hz();
        st = h || (!b && hz);
        check({tag, "_comb"}, {61'h0, pc_stall, ifid_stall, ifid_flush}, {61'h0, st, st, b});
        if (h) begin
            m_state = S_HALT; m_halted = 1'b1; m_valid = 1'b0;
        end else if (b) begin
            m_state = S_RUN;  m_halted = 1'b0; m_valid = 1'b0;
        end else if (hz) begin
            m_state = S_STALL; m_halted = 1'b0; m_valid = 1'b0;
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else begin
            m_state = S_RUN;  m_halted = 1'b0; m_valid = id_valid;
            m_op    = id_ext_op;
            m_imm   = tb_ext(id_ext_op, id_imm, id_shamt);
        end
        exp_q.push_back(model_regs());
        @(posedge clk);
        #1;
        check({tag, "_regs"}, obs_regs(), exp_q.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] ext_lit [4];

    initial begin
        checks   = 0;
        failures = 0;
        ext_lit  = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0011, 32'h0000_0000};
        model_reset();
        clear_inputs();
        rst_n = 1'b0;

        // Reset: comb outputs suppressed even with halt/branch requested.
        halt_req        = 1'b1;
        ex_branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_comb", {61'h0, pc_stall, ifid_stall, ifid_flush}, 64'h0);
        check("rst_regs", obs_regs(), 64'h0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        step("idle");

        // Immediate extension for every op.
        id_valid = 1'b1;
        id_imm   = 16'h8001;
        id_shamt = 5'd17;
        for (int i = 0; i < 4; i++) begin
            id_ext_op = 2'(i);
            step($sformatf("ext_op%0d", i));
            check($sformatf("ext_lit%0d", i), {32'h0, idex_imm32}, {32'h0, ext_lit[i]});
        end

        // Load-use on rs.
        clear_inputs();
        set_load_use_rs8();
        id_rt      = 5'd3;
        id_uses_rt = 1'b1;
        id_imm     = 16'h1234;
        id_ext_op  = 2'b01;
        cnt0       = m_cnt;
        step("lu_ex");
        check("lu_first_bubble", {48'h0, stall_cnt}, {48'h0, cnt0 + 16'd1});
        ex_mem_read   = 1'b0;
        ex_reg_write  = 1'b0;
        ex_wr_reg     = 5'd0;
        mem_reg_write = 1'b1;
        mem_wr_reg    = 5'd8;
        step("lu_mem");
        mem_reg_write = 1'b0;
        mem_wr_reg    = 5'd0;
        step("lu_go");
        check("lu_total", {48'h0, stall_cnt}, 64'(cnt0) + 64'(LU_BUBBLES));
        check("lu_imm", {32'h0, idex_imm32}, 64'h1234);

        // ALU RAW on rt: EX match then MEM match.
        clear_inputs();
        id_valid     = 1'b1;
        id_rs        = 5'd4;
        id_uses_rs   = 1'b1;
        id_rt        = 5'd9;
        id_uses_rt   = 1'b1;
        id_imm       = 16'h00FF;
        ex_reg_write = 1'b1;
        ex_wr_reg    = 5'd9;
        cnt0         = m_cnt;
        step("raw_ex");
        ex_reg_write  = 1'b0;
        ex_wr_reg     = 5'd0;
        mem_reg_write = 1'b1;
        mem_wr_reg    = 5'd9;
        step("raw_mem");
        mem_reg_write = 1'b0;
        mem_wr_reg    = 5'd0;
        step("raw_go");
        check("raw_total", {48'h0, stall_cnt}, 64'(cnt0) + 64'(RAW_BUBBLES));
        check("raw_valid", {63'h0, idex_valid}, 64'h1);

        // $zero, unused source, and invalid ID never hazard.
        id_rs         = 5'd0;
        id_rt         = 5'd0;
        ex_reg_write  = 1'b1;
        ex_mem_read   = 1'b1;
        ex_wr_reg     = 5'd0;
        mem_reg_write = 1'b1;
        mem_wr_reg    = 5'd0;
        step("zero_reg");
        id_rs      = 5'd5;
        id_uses_rs = 1'b0;
        ex_wr_reg  = 5'd5;
        mem_wr_reg = 5'd5;
        step("unused_src");
        id_valid   = 1'b0;
        id_uses_rs = 1'b1;
        step("invalid_id");

        // Branch together with a hazard: flush wins, counter untouched.
        clear_inputs();
        set_load_use_rs8();
        ex_branch_taken = 1'b1;
        cnt0            = m_cnt;
        step("br_hz");
        check("br_cnt", {48'h0, stall_cnt}, {48'h0, cnt0});
        // Branch beats halt, halt follows next cycle.
        clear_inputs();
        ex_branch_taken = 1'b1;
        halt_req        = 1'b1;
        step("br_halt");
        ex_branch_taken = 1'b0;
        step("halt_after_br");
        halt_req = 1'b0;
        step("halt_after_br_rel");

        // Halt held for 3 cycles, then normal advance.
        clear_inputs();
        id_valid  = 1'b1;
        id_imm    = 16'h0042;
        id_ext_op = 2'b01;
        halt_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("halt%0d", i));
            check($sformatf("halt%0d_flag", i), {63'h0, halted}, 64'h1);
        end
        halt_req = 1'b0;
        id_imm   = 16'h0077;
        step("halt_release");
        check("halt_release_imm", {32'h0, idex_imm32}, 64'h77);
        check("halt_release_flag", {62'h0, halted, idex_valid}, 64'h1);

        // Async reset in the middle of a STALL.
        clear_inputs();
        set_load_use_rs8();
        step("pre_rst");
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_comb", {61'h0, pc_stall, ifid_stall, ifid_flush}, 64'h0);
        check("async_rst_regs", obs_regs(), 64'h0);
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        step("post_rst");

        // Counter saturation under a permanently held hazard.
        set_load_use_rs8();
        repeat (65540) @(posedge clk);
        #1;
        m_state  = S_STALL;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_cnt    = {CNT_W{1'b1}};
        exp_q.push_back(model_regs());
        check("sat_regs", obs_regs(), exp_q.pop_front());
        check("sat_lit", {48'h0, stall_cnt}, 64'hFFFF);
        step("sat_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
